// File: rtl/bf_pkg.sv
// Shared types for the bf_core_p Brainfuck interpreter core: opcode and FSM state encodings.
package bf_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_INC   = 3'd0,
    OP_DEC   = 3'd1,
    OP_RIGHT = 3'd2,
    OP_LEFT  = 3'd3,
    OP_OPEN  = 3'd4,
    OP_CLOSE = 3'd5,
    OP_OUT   = 3'd6,
    OP_IN    = 3'd7
  } op_t;

  typedef enum logic [2:0] {
    FETCH    = 3'd0,
    EXEC     = 3'd1,
    LOAD     = 3'd2,
    SKIP_F   = 3'd3,
    SKIP_B   = 3'd4,
    OUT_WAIT = 3'd5,
    IN_WAIT  = 3'd6,
    HALT     = 3'd7
  } state_t;

endpackage

// File: rtl/bf_core_p.sv
// Brainfuck interpreter core with external program/tape memories (1-cycle read latency).
// Macro BF_INPUT_EN enables the ',' input stream; otherwise ',' stores 0.
module bf_core_p
  import bf_pkg::*;
#(
  parameter int CELL_W  = 8,
  parameter int TAPE_AW = 16,
  parameter int PC_W    = 16,
  parameter int NEST_W  = 8
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [PC_W-1:0]    prog_len,
  output logic [PC_W-1:0]    pc,
  input  logic [OP_W-1:0]    pmem_data_read,
  output logic [TAPE_AW-1:0] sp,
  output logic               tape_we,
  output logic [CELL_W-1:0]  tape_data_write,
  input  logic [CELL_W-1:0]  tape_data_read,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CELL_W-1:0]  out_data,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [CELL_W-1:0]  in_data,
  output logic               halted,
  output logic               error,
  output state_t             dbg_state
);

  // Handshakes: a beat transfers on a rising edge where valid && ready; valid/ready
  // come only from the state register, and out_data holds the cell, so it stays stable.
  state_t              state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [TAPE_AW-1:0]  sp_q, sp_d;
  logic [CELL_W-1:0]   cell_q, cell_d;
  logic [NEST_W-1:0]   depth_q, depth_d;
  logic                err_q, err_d;
  logic                phase_q, phase_d;
  op_t                 op;

  assign op = op_t'(pmem_data_read);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= FETCH;
      pc_q    <= '0;
      sp_q    <= '0;
      cell_q  <= '0;
      depth_q <= '0;
      err_q   <= 1'b0;
      phase_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      sp_q    <= sp_d;
      cell_q  <= cell_d;
      depth_q <= depth_d;
      err_q   <= err_d;
      phase_q <= phase_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    sp_d      = sp_q;
    cell_d    = cell_q;
    depth_d   = depth_q;
    err_d     = err_q;
    phase_d   = phase_q;
    tape_we   = 1'b0;
    out_valid = 1'b0;
    in_ready  = 1'b0;
    halted    = 1'b0;
    case (state_q)
      FETCH: begin
        if (pc_q == prog_len) begin
          state_d = HALT;
          err_d   = 1'b0;
        end else begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        case (op)
          OP_INC, OP_DEC: begin
            cell_d  = (op == OP_INC) ? cell_q + CELL_W'(1) : cell_q - CELL_W'(1);
            tape_we = 1'b1;
            pc_d    = pc_q + PC_W'(1);
            state_d = FETCH;
          end
          OP_RIGHT, OP_LEFT: begin
            sp_d    = (op == OP_RIGHT) ? sp_q + TAPE_AW'(1) : sp_q - TAPE_AW'(1);
            pc_d    = pc_q + PC_W'(1);
            state_d = LOAD;
          end
          OP_OPEN: begin
            pc_d = pc_q + PC_W'(1);
            if (cell_q == '0) begin
              depth_d = NEST_W'(1);
              phase_d = 1'b0;
              state_d = SKIP_F;
            end else begin
              state_d = FETCH;
            end
          end
          OP_CLOSE: begin
            if (cell_q == '0) begin
              pc_d    = pc_q + PC_W'(1);
              state_d = FETCH;
            end else if (pc_q == '0) begin
              state_d = HALT;
              err_d   = 1'b1;
            end else begin
              depth_d = NEST_W'(1);
              phase_d = 1'b0;
              pc_d    = pc_q - PC_W'(1);
              state_d = SKIP_B;
            end
          end
          OP_OUT: state_d = OUT_WAIT;
          OP_IN: begin
`ifdef BF_INPUT_EN
            state_d = IN_WAIT;
`else
            cell_d  = '0;
            tape_we = 1'b1;
            pc_d    = pc_q + PC_W'(1);
            state_d = FETCH;
`endif
          end
          default: state_d = FETCH;
        endcase
      end
      // sp already points at the new cell; its read data arrives this cycle.
      LOAD: begin
        cell_d  = tape_data_read;
        state_d = FETCH;
      end
      SKIP_F: begin
        if (!phase_q) begin
          if (pc_q == prog_len) begin
            state_d = HALT;
            err_d   = 1'b1;
          end else begin
            phase_d = 1'b1;
          end
        end else begin
          phase_d = 1'b0;
          pc_d    = pc_q + PC_W'(1);
          if (op == OP_OPEN) begin
            if (depth_q == '1) begin
              state_d = HALT;
              err_d   = 1'b1;
            end else begin
              depth_d = depth_q + NEST_W'(1);
            end
          end else if (op == OP_CLOSE) begin
            depth_d = depth_q - NEST_W'(1);
            if (depth_q == NEST_W'(1)) state_d = FETCH;
          end
        end
      end
      SKIP_B: begin
        if (!phase_q) begin
          phase_d = 1'b1;
        end else begin
          phase_d = 1'b0;
          if (op == OP_CLOSE && depth_q == '1) begin
            state_d = HALT;
            err_d   = 1'b1;
          end else if (op == OP_OPEN && depth_q == NEST_W'(1)) begin
            depth_d = '0;
            pc_d    = pc_q + PC_W'(1);
            state_d = FETCH;
          end else begin
            if (op == OP_OPEN) depth_d = depth_q - NEST_W'(1);
            if (op == OP_CLOSE) depth_d = depth_q + NEST_W'(1);
            if (pc_q == '0) begin
              state_d = HALT;
              err_d   = 1'b1;
            end else begin
              pc_d = pc_q - PC_W'(1);
            end
          end
        end
      end
      OUT_WAIT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          pc_d    = pc_q + PC_W'(1);
          state_d = FETCH;
        end
      end
      IN_WAIT: begin
`ifdef BF_INPUT_EN
        in_ready = 1'b1;
        if (in_valid) begin
          cell_d  = in_data;
          tape_we = 1'b1;
          pc_d    = pc_q + PC_W'(1);
          state_d = FETCH;
        end
`else
        state_d = FETCH;
`endif
      end
      HALT: halted = 1'b1;
      default: state_d = HALT;
    endcase
  end

`ifndef BF_INPUT_EN
  logic unused_in;
  assign unused_in = ^{in_valid, in_data};
`endif

  // The tape address is presented a cycle early so LOAD sees the moved-to cell.
  assign sp              = sp_d;
  assign pc              = pc_q;
  assign tape_data_write = cell_d;
  assign out_data        = cell_q;
  assign error           = err_q;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_bf_core_p.sv
// Self-checking bench for bf_core_p: reset checks, vector table, handshake corner cases
// and random programs against a tape-level interpreter model.
module tb_bf_core_p;
  import bf_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] prog_len = '0;
  logic [15:0] pc;
  logic [2:0]  pmem_data_read = '0;
  logic [15:0] sp;
  logic        tape_we;
  logic [7:0]  tape_data_write;
  logic [7:0]  tape_data_read = '0;
  logic        out_valid, out_ready = 1'b0;
  logic [7:0]  out_data;
  logic        in_valid = 1'b0, in_ready;
  logic [7:0]  in_data = '0;
  logic        halted, error;
  state_t      dbg_state;

  bf_core_p dut (
    .clock(clock), .reset_n(reset_n), .prog_len(prog_len), .pc(pc),
    .pmem_data_read(pmem_data_read), .sp(sp), .tape_we(tape_we),
    .tape_data_write(tape_data_write), .tape_data_read(tape_data_read),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .halted(halted), .error(error), .dbg_state(dbg_state)
  );

  always #5 clock = ~clock;

  logic [2:0] prog [0:255] = '{default: '0};
  logic [7:0] tape [0:65535] = '{default: '0};
  logic [7:0] snap [0:65535];

  always @(posedge clock) begin
    pmem_data_read <= prog[pc[7:0]];
    if (tape_we) tape[sp] <= tape_data_write;
    tape_data_read <= tape[sp];
  end

`ifdef BF_INPUT_EN
  localparam logic [7:0] IN_EXP = 8'd42;
  localparam bit IN_EN = 1'b1;
`else
  localparam logic [7:0] IN_EXP = 8'd0;
  localparam bit IN_EN = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] in_list[$];
  logic [7:0] m_tape [int];
  bit  m_err, m_ok;
  int  run_cycles, we_count;
  bit  run_to;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [2:0] char2op(input byte c);
    case (c)
      "+": return 3'd0;
      "-": return 3'd1;
      ">": return 3'd2;
      "<": return 3'd3;
      "[": return 3'd4;
      "]": return 3'd5;
      ".": return 3'd6;
      default: return 3'd7;
    endcase
  endfunction

  task automatic load_prog(input string p);
    for (int i = 0; i < p.len(); i++) prog[i] = char2op(p[i]);
    prog_len = 16'(p.len());
  endtask

  task automatic reset_core();
    @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  // Runs the loaded program to HALT, collecting output beats into got_q.
  task automatic run_prog(input string p, input int ready_pct, input int budget);
    int in_idx = 0;
    load_prog(p);
    snap = tape;
    got_q.delete();
    we_count = 0;
    out_ready = 1'b0;
    in_valid = 1'b0;
    reset_core();
    run_cycles = 0;
    while (!halted && run_cycles < budget) begin
      out_ready = ($urandom_range(0, 99) < ready_pct);
      if (out_valid && out_ready) got_q.push_back(out_data);
      in_valid = ($urandom_range(0, 99) < 60);
      in_data  = (in_idx < in_list.size()) ? in_list[in_idx] : 8'd0;
      if (in_valid && in_ready) in_idx++;
      if (tape_we) we_count++;
      @(posedge clock);
      run_cycles++;
      @(negedge clock);
    end
    run_to = !halted;
    out_ready = 1'b0;
    in_valid = 1'b0;
  endtask

  function automatic logic [7:0] mrd(input int a);
    return m_tape.exists(a) ? m_tape[a] : snap[a];
  endfunction

  // Interpreter over the tape itself: brackets resolved by scanning the program text.
  task automatic model_run(input string p);
    int ip = 0, ptr = 0, steps = 0, k = 0, depth, j;
    logic [7:0] cur = 8'd0;
    m_tape.delete();
    exp_q.delete();
    m_err = 1'b0;
    m_ok  = 1'b1;
    while (ip < p.len()) begin
      steps++;
      if (steps > 200) begin m_ok = 1'b0; return; end
      case (p[ip])
        "+": begin cur = cur + 8'd1; m_tape[ptr] = cur; end
        "-": begin cur = cur - 8'd1; m_tape[ptr] = cur; end
        ">": begin ptr = (ptr + 1) % 65536; cur = mrd(ptr); end
        "<": begin ptr = (ptr + 65535) % 65536; cur = mrd(ptr); end
        ".": exp_q.push_back(cur);
        ",": begin
          cur = (IN_EN && k < in_list.size()) ? in_list[k] : 8'd0;
          k++;
          m_tape[ptr] = cur;
        end
        "[": if (cur == 8'd0) begin
          depth = 1; j = ip;
          while (depth > 0) begin
            j++;
            if (j >= p.len()) begin m_err = 1'b1; return; end
            if (p[j] == "[") depth++;
            if (p[j] == "]") depth--;
          end
          ip = j;
        end
        "]": if (cur != 8'd0) begin
          depth = 1; j = ip;
          while (depth > 0) begin
            if (j == 0) begin m_err = 1'b1; return; end
            j--;
            if (p[j] == "]") depth++;
            if (p[j] == "[") depth--;
          end
          ip = j;
        end
        default: ;
      endcase
      ip++;
    end
  endtask

  typedef struct {
    string      prog;
    int         n_out;
    logic [7:0] o0;
    logic       err;
    int         cyc;
  } vec_t;

  vec_t vecs[12];

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    string p, c;
    string cs = "++-><[].,+>.";
    vecs[0]  = '{"<+.",           1, 8'd1,   1'b0, 9};
    vecs[1]  = '{"+++.",          1, 8'd3,   1'b0, 10};
    vecs[2]  = '{"-.",            1, 8'd255, 1'b0, 6};
    vecs[3]  = '{"[+++].",        1, 8'd0,   1'b0, 0};
    vecs[4]  = '{"++[-].",        1, 8'd0,   1'b0, 0};
    vecs[5]  = '{"[[",            0, 8'd0,   1'b1, 0};
    vecs[6]  = '{",.",            1, IN_EXP, 1'b0, 0};
    vecs[7]  = '{"",              0, 8'd0,   1'b0, 1};
    vecs[8]  = '{"+]",            0, 8'd0,   1'b1, 0};
    vecs[9]  = '{"+++[>++<-]>.",  1, 8'd6,   1'b0, 0};
    vecs[10] = '{"].",            1, 8'd0,   1'b0, 0};
    vecs[11] = '{"[",             0, 8'd0,   1'b1, 0};

    // Reset state
    repeat (2) @(negedge clock);
    chk("rst_pc", pc, 0);
    chk("rst_sp", sp, 0);
    chk("rst_we", tape_we, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_halted", halted, 0);
    chk("rst_error", error, 0);
    chk("rst_state", dbg_state, FETCH);

    // Vector table, out_ready always high so cycle counts are exact
    for (int i = 0; i < 12; i++) begin
      in_list.delete();
      repeat (8) in_list.push_back(8'd42);
      run_prog(vecs[i].prog, 100, 2000);
      chk({"vec_timeout_", vecs[i].prog}, run_to, 0);
      chk({"vec_error_", vecs[i].prog}, error, vecs[i].err);
      chk({"vec_nout_", vecs[i].prog}, got_q.size(), vecs[i].n_out);
      if (vecs[i].n_out > 0 && got_q.size() > 0) chk({"vec_data_", vecs[i].prog}, got_q[0], vecs[i].o0);
      if (vecs[i].cyc > 0) chk({"vec_cycles_", vecs[i].prog}, run_cycles, vecs[i].cyc);
      chk({"vec_halt_out_valid_", vecs[i].prog}, out_valid, 0);
      chk({"vec_halt_in_ready_", vecs[i].prog}, in_ready, 0);
      if (i == 0) chk("wrap_tape_65535", tape[65535], 1);
      if (i == 4) chk("loop_tape_writes", we_count, 4);
    end

    // Output stall: out_valid/out_data held for 10 cycles without out_ready
    load_prog("+.");
    out_ready = 1'b0;
    reset_core();
    n = 0;
    while (!out_valid && n < 20) begin @(posedge clock); @(negedge clock); n++; end
    chk("stall_reach_cycles", n, 4);
    for (int k = 0; k < 10; k++) begin
      chk("stall_valid", out_valid, 1);
      chk("stall_data", out_data, 1);
      @(posedge clock); @(negedge clock);
    end
    out_ready = 1'b1;
    @(posedge clock); @(negedge clock);
    chk("stall_done_valid", out_valid, 0);
    chk("stall_done_state", dbg_state, FETCH);
    @(posedge clock); @(negedge clock);
    chk("stall_halted", halted, 1);
    chk("stall_error", error, 0);
    out_ready = 1'b0;

    // Reset asserted while a beat is offered drops out_valid at once
    load_prog(".");
    reset_core();
    n = 0;
    while (!out_valid && n < 20) begin @(posedge clock); @(negedge clock); n++; end
    chk("midrst_reach", out_valid, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_state", dbg_state, FETCH);
    chk("midrst_pc", pc, 0);
    @(negedge clock);
    reset_n = 1'b1;

    // Random programs against the interpreter model
    for (int t = 0; t < 25; t++) begin
      int tries = 0;
      in_list.delete();
      repeat (32) in_list.push_back(8'($urandom));
      do begin
        p = "";
        n = $urandom_range(3, 20);
        for (int i = 0; i < n; i++) begin
          int s = $urandom_range(0, 11);
          c = cs.substr(s, s);
          p = {p, c};
        end
        snap = tape;
        model_run(p);
        tries++;
      end while (!m_ok && tries < 50);
      if (m_ok) begin
        run_prog(p, 70, 10000);
        chk({"rnd_timeout_", p}, run_to, 0);
        chk({"rnd_error_", p}, error, m_err);
        chk({"rnd_nout_", p}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
          chk({"rnd_data_", p}, got_q[i], exp_q[i]);
        foreach (m_tape[a]) chk({"rnd_tape_", p}, tape[a[15:0]], m_tape[a]);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
